dense_argmax_classifier: RTL
============================

# dense_argmax_classifier

Downstream consumer of the encoder dense layer's output BRAM. Once the dense layer reports done, it sweeps all `neuron` ReLU outputs through the dense layer's read port. It finds the signed maximum and its index, then presents the winning class index, winning value and a sticky done flag to the next stage (top-level result register / host readout).

## Interface
- `neuron`, 100, number of dense outputs to scan (addresses 0..neuron-1); legal range 1..128
- `integer_width`, 10, integer bits of the Qi.f signed fixed-point data
- `fraction_width`, 10, fraction bits; data width W = integer_width+fraction_width
- `read_latency`, 2, clock edges from this block updating `dense_output_address` to the edge where the matching `dense_output_data` is sampled; legal range 1..4
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state and outputs
- `enableOperation`  input  1  start qualifier; tie to the dense layer's `done`. The dense layer only routes its BRAM address to `dense_output_address` while its `done` is high.
- `dense_output_address`  output  7  read address into the dense output BRAM
- `dense_output_enable`  output  1  read enable into the dense output BRAM
- `dense_output_data`  input  W  signed ReLU output read back from the BRAM
- `class_index`  output  7  index of the maximum output
- `max_value`  output  W  signed value at `class_index`
- `done`  output  1  result valid; sticky until reset

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: outputs hold reset values. On an edge with `enableOperation`=1: address<=0, enable<=1, go to SWEEP. This is the start edge, E0.
- SWEEP: address increments by 1 on every edge. The edge that loads address neuron-1 moves to DRAIN. If neuron=1, go directly from IDLE to DRAIN.
- DRAIN: enable<=0, address holds at neuron-1. Wait until the last sample is consumed.
- Sample tracking:
  - A valid shift register of depth `read_latency` is tagged with the issued index.
  - A sample is consumed on the edge where its tag exits the shift register.
  - The first sample (index 0) loads `max_value`/`class_index` unconditionally.
  - Each later sample replaces them only if `$signed(data) > $signed(max_value)`. Ties keep the earlier, lower index.
- On the edge that consumes index neuron-1: the final compare result is registered and done<=1 on the same edge. Go to DONE.
- DONE: all outputs hold; enable stays 0. `enableOperation` is ignored. Only reset re-arms the block, matching the sticky done of the upstream layer.
- `enableOperation` dropping during SWEEP/DRAIN is ignored. The sweep completes.
- Arithmetic: comparison only, full W-bit signed. No saturation and no rounding.

## Timing
- Reset values: `dense_output_address`=0, `dense_output_enable`=0, `class_index`=0, `max_value`=0, `done`=0. State=IDLE, valid pipeline cleared.
- Address k is driven after edge Ek. Its data is sampled at edge E(k+read_latency).
- Addresses are issued back-to-back, one per cycle, with no bubbles. Throughput is 1 sample/clk.
- `done`, `class_index` and `max_value` become valid together after edge E(neuron-1+read_latency). Defaults: E101 (101 cycles after start).
- `dense_output_enable` is high exactly `neuron` cycles, from after E0 through after E(neuron-1).
- Reset asserted mid-SWEEP/DRAIN: outputs go to reset values immediately (async). Partial results are discarded. After release the block waits in IDLE for `enableOperation`.
- `enableOperation` already high when reset releases: start on the first edge after release.

## Test plan
- All outputs zero except dense[37]=0x00C00 (3.0), defaults -> `done` rises after E101, class_index=37, max_value=0x00C00; enable high exactly 100 cycles.
- Tie: dense[5]=dense[80]=0x00400, the rest 0x00100 -> class_index=5, max_value=0x00400.
- Max at boundaries: run once with the maximum only at index 0, once only at index 99 -> class_index=0 and 99 respectively. The index-99 case checks that the last sample is not dropped in DRAIN.
- Signed compare: force dense[10]=0xFFC00 (-1.0) and the rest equal to -2.0 (0xFF800) -> class_index=10. Also check the compare is not unsigned.
- read_latency=1 and =3 builds with dense[50] max -> `done` after E100 / E102, class_index=50.
- Reset asserted at E40 then released, `enableOperation` held high -> outputs zero during reset. Full rescan restarts at address 0 and gives the correct result; `done` stays high afterwards even when `enableOperation` is deasserted.

Source files
------------

// File: rtl/dense_argmax_classifier.sv
// Sweeps the dense layer's output BRAM once after it reports done and keeps the
// signed maximum and its index; the result is sticky until reset.
module dense_argmax_classifier #(
  parameter int neuron         = 100,
  parameter int integer_width  = 10,
  parameter int fraction_width = 10,
  parameter int read_latency   = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enableOperation,
  output logic [6:0]                              dense_output_address,
  output logic                                    dense_output_enable,
  input  logic [integer_width+fraction_width-1:0] dense_output_data,
  output logic [6:0]                              class_index,
  output logic [integer_width+fraction_width-1:0] max_value,
  output logic                                    done
);

  localparam int         W    = integer_width + fraction_width;
  localparam logic [6:0] LAST = 7'(neuron - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [6:0]              addr_q, addr_d;
  logic                    en_q, en_d;
  logic                    done_q, done_d;
  logic [W-1:0]            max_q, max_d;
  logic [6:0]              idx_q, idx_d;
  logic [read_latency-1:0] vld_q;
  logic [6:0]              tag_q [read_latency];

  logic                    iss_v;
  logic [6:0]              iss_t;
  logic                    cons_v;
  logic [6:0]              cons_t;

  // The tag leaving the last stage identifies the sample on dense_output_data now.
  assign cons_v = vld_q[read_latency-1];
  assign cons_t = tag_q[read_latency-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < read_latency; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      done_q   <= done_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      vld_q[0] <= iss_v;
      tag_q[0] <= iss_t;
      for (int i = 1; i < read_latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    done_d  = done_q;
    max_d   = max_q;
    idx_d   = idx_q;
    iss_v   = 1'b0;
    iss_t   = addr_q;

    // Index 0 seeds the running maximum; ties keep the earlier index.
    if (cons_v) begin
      if ((cons_t == 7'd0) || ($signed(dense_output_data) > $signed(max_q))) begin
        max_d = dense_output_data;
        idx_d = cons_t;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enableOperation) begin
          addr_d  = '0;
          en_d    = 1'b1;
          iss_v   = 1'b1;
          iss_t   = '0;
          state_d = (LAST == 7'd0) ? S_DRAIN : S_SWEEP;
        end
      end
      S_SWEEP: begin
        addr_d = addr_q + 7'd1;
        iss_v  = 1'b1;
        iss_t  = addr_q + 7'd1;
        if (addr_q + 7'd1 == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        en_d = 1'b0;
        if (cons_v && (cons_t == LAST)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        en_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dense_output_address = addr_q;
  assign dense_output_enable  = en_q;
  assign class_index          = idx_q;
  assign max_value            = max_q;
  assign done                 = done_q;

endmodule
